ram_entry_loader: RTL and testbench

Control-plane loader that sits directly upstream of the 267-bit x 16-entry table RAM on its `axi_clk` port. Software writes a 267-bit entry as nine 32-bit words into a staging register, then issues a command word that commits the entry to a RAM address or reads a RAM entry back into staging. A small FSM sequences the RAM's one-cycle registered-read latency and reports busy/done status. The RAM's `axis_clk` lookup port is untouched by this block.

---
 rtl/ram_cfg_pkg.sv | 55 +++++
 rtl/ram_entry_loader.sv | 231 +++++++++++++++++++++++
 tb/tb_ram_entry_loader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_cfg_pkg.sv
// ----------------------------------------------------------------------------
// ram_cfg_pkg
// Shared constants for the table-RAM entry loader: config register indices,
// CMD / STATUS bit positions, the loader FSM encoding and helpers that split a
// wide RAM entry into 32-bit config words.
// ----------------------------------------------------------------------------
package ram_cfg_pkg;

    // Default geometry of the table RAM and the config bus.
    localparam int DEF_DATA_WIDTH = 267;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_CFG_WIDTH  = 32;
    localparam int IDX_WIDTH      = 4;

    // Number of config words needed to cover one entry (ceiling division).
    function automatic int num_words(input int dw, input int cw);
        return (dw + cw - 1) / cw;
    endfunction

    localparam int NUM_WORDS = num_words(DEF_DATA_WIDTH, DEF_CFG_WIDTH);

    // Number of live bits in config word k; only the last word is partial.
    function automatic int word_bits(input int k, input int dw, input int cw);
        int rem;
        rem = dw - k * cw;
        return (rem >= cw) ? cw : rem;
    endfunction

    // Register map.
    localparam logic [IDX_WIDTH-1:0] IDX_DATA0     = 4'd0;
    localparam logic [IDX_WIDTH-1:0] IDX_DATA_LAST = IDX_DATA0 + IDX_WIDTH'(NUM_WORDS - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_CMD       = 4'd9;
    localparam logic [IDX_WIDTH-1:0] IDX_STATUS    = 4'd10;

    // CMD word fields.
    localparam int CMD_GO_BIT   = 0;
    localparam int CMD_OP_BIT   = 1;
    localparam int CMD_ADDR_LSB = 4;

    // STATUS word fields.
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int STATUS_OP_BIT   = 2;
    localparam int STATUS_ADDR_LSB = 4;

    // Loader FSM.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_CAP  = 3'd4
    } state_t;

endpackage

// File: rtl/ram_entry_loader.sv
// ----------------------------------------------------------------------------
// ram_entry_loader
// Control-plane loader in front of the axi_clk port of the wide table RAM.
// Software fills a staging register one 32-bit word at a time, then writes a
// CMD word that either commits staging to a RAM entry or pulls a RAM entry
// back into staging. A small FSM sequences the RAM's one-cycle read latency.
//
// Ports
//   axi_clk, axi_rst             clock, synchronous active-high reset
//   cfg_wr_valid/ready/idx/data  config write channel (stalls while busy)
//   cfg_rd_valid/ready/idx       config read request (always accepted)
//   cfg_rd_data/_valid           registered read response, one cycle later
//   ram_wr_en/addr/data          RAM write port (axi_wr_en/addr/data_in)
//   ram_rd_en/addr               RAM read request (axi_rd_en/addr)
//   ram_rd_data                  RAM read data, valid one cycle after rd_en
//   dbg_state                    current FSM state, for observation only
//
// Handshake: a config write transfers on a rising edge where cfg_wr_valid and
// cfg_wr_ready are both high; the source holds idx/data stable while valid is
// high and not ready. A read request transfers on any edge where cfg_rd_valid
// and cfg_rd_ready are high, and its response is presented with
// cfg_rd_data_valid for exactly the following cycle.
// ----------------------------------------------------------------------------
module ram_entry_loader
    import ram_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CFG_WIDTH  = DEF_CFG_WIDTH
) (
    input  logic                  axi_clk,
    input  logic                  axi_rst,
    input  logic                  cfg_wr_valid,
    output logic                  cfg_wr_ready,
    input  logic [IDX_WIDTH-1:0]  cfg_wr_idx,
    input  logic [CFG_WIDTH-1:0]  cfg_wr_data,
    input  logic                  cfg_rd_valid,
    output logic                  cfg_rd_ready,
    input  logic [IDX_WIDTH-1:0]  cfg_rd_idx,
    output logic [CFG_WIDTH-1:0]  cfg_rd_data,
    output logic                  cfg_rd_data_valid,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [2:0]            dbg_state
);

    localparam int N_WORDS = num_words(DATA_WIDTH, CFG_WIDTH);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_finish;
    logic                  w_wr_strobe;
    logic                  w_rd_strobe;

    logic [DATA_WIDTH-1:0] r_staging;
    logic [DATA_WIDTH-1:0] w_staging_nxt;
    logic [DATA_WIDTH-1:0] r_cap;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_op;
    logic                  r_done;
    logic [CFG_WIDTH-1:0]  r_rd_data;
    logic                  r_rd_valid;

    logic                  w_idle;
    logic                  w_wr_fire;
    logic                  w_cmd_go;
    logic                  w_cmd_op;
    logic [CFG_WIDTH-1:0]  w_words [N_WORDS];
    logic [CFG_WIDTH-1:0]  w_status;
    logic [CFG_WIDTH-1:0]  w_rd_word;

    // ------------------------------------------------------------------
    // Config write acceptance
    // ------------------------------------------------------------------
    assign w_idle       = (r_state == ST_IDLE);
    assign cfg_wr_ready = w_idle && !axi_rst;
    assign cfg_rd_ready = !axi_rst;
    assign w_wr_fire    = cfg_wr_valid && cfg_wr_ready;
    // A CMD write with go = 0 is accepted but otherwise has no effect.
    assign w_cmd_go     = w_wr_fire && (cfg_wr_idx == IDX_CMD) && cfg_wr_data[CMD_GO_BIT];
    assign w_cmd_op     = cfg_wr_data[CMD_OP_BIT];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_finish    = 1'b0;
        w_wr_strobe = 1'b0;
        w_rd_strobe = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_cmd_go) begin
                    w_state_nxt = w_cmd_op ? ST_RD_REQ : ST_WR;
                end
            end
            ST_WR: begin
                w_wr_strobe = 1'b1;
                w_finish    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_RD_REQ: begin
                w_rd_strobe = 1'b1;
                w_state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // RAM output is valid in this cycle; r_cap samples it.
                w_state_nxt = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                w_finish    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Strobes are suppressed during reset so a reset landing mid-command
    // never lets a RAM access slip out in the reset cycle itself.
    assign ram_wr_en   = w_wr_strobe && !axi_rst;
    assign ram_rd_en   = w_rd_strobe && !axi_rst;
    assign ram_wr_addr = r_addr;
    assign ram_rd_addr = r_addr;
    assign ram_wr_data = r_staging;
    assign dbg_state   = r_state;

    // ------------------------------------------------------------------
    // Command / status registers
    // ------------------------------------------------------------------
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_addr <= '0;
            r_op   <= 1'b0;
            r_done <= 1'b0;
        end else if (w_cmd_go) begin
            r_addr <= cfg_wr_data[CMD_ADDR_LSB +: ADDR_WIDTH];
            r_op   <= w_cmd_op;
            r_done <= 1'b0;
        end else if (w_finish) begin
            r_done <= 1'b1;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_cap <= '0;
        end else if (r_state == ST_RD_WAIT) begin
            r_cap <= ram_rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Staging register, viewed as config words
    // ------------------------------------------------------------------
    for (genvar k = 0; k < N_WORDS; k++) begin : g_word
        localparam int LO = k * CFG_WIDTH;
        localparam int W  = word_bits(k, DATA_WIDTH, CFG_WIDTH);

        // Writes only keep the live bits of a partial word; reads fill the
        // dead upper bits with zero. Config writes cannot coincide with
        // RD_CAP because the write channel stalls while busy.
        assign w_staging_nxt[LO +: W] =
            (r_state == ST_RD_CAP)                                            ? r_cap[LO +: W] :
            (w_wr_fire && (cfg_wr_idx == (IDX_DATA0 + IDX_WIDTH'(k))))        ? cfg_wr_data[W-1:0] :
                                                                                r_staging[LO +: W];

        if (W == CFG_WIDTH) begin : g_full
            assign w_words[k] = r_staging[LO +: W];
        end else begin : g_part
            assign w_words[k] = {{(CFG_WIDTH - W){1'b0}}, r_staging[LO +: W]};
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_staging <= '0;
        end else begin
            r_staging <= w_staging_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and registered response
    // ------------------------------------------------------------------
    always_comb begin
        w_status                                  = '0;
        w_status[STATUS_BUSY_BIT]                 = !w_idle;
        w_status[STATUS_DONE_BIT]                 = r_done;
        w_status[STATUS_OP_BIT]                   = r_op;
        w_status[STATUS_ADDR_LSB +: ADDR_WIDTH]   = r_addr;

        w_rd_word = '0;
        if (cfg_rd_idx <= IDX_DATA_LAST) begin
            w_rd_word = w_words[cfg_rd_idx - IDX_DATA0];
        end else if (cfg_rd_idx == IDX_STATUS) begin
            w_rd_word = w_status;
        end
    end

    // Sampled from pre-edge state, so a same-cycle write to the same index
    // is not visible in this response.
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= cfg_rd_valid;
            if (cfg_rd_valid) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    assign cfg_rd_data       = r_rd_data;
    assign cfg_rd_data_valid = r_rd_valid;

endmodule

// File: tb/tb_ram_entry_loader.sv
// ----------------------------------------------------------------------------
// tb_ram_entry_loader
// Bench for ram_entry_loader with a registered-read RAM model attached to the
// loader's RAM port and a transaction-level model of the register file.
// ----------------------------------------------------------------------------
module tb_ram_entry_loader;

    localparam int DW = 267;

    logic           clk;
    logic           rst;
    logic           cfg_wr_valid;
    logic           cfg_wr_ready;
    logic [3:0]     cfg_wr_idx;
    logic [31:0]    cfg_wr_data;
    logic           cfg_rd_valid;
    logic           cfg_rd_ready;
    logic [3:0]     cfg_rd_idx;
    logic [31:0]    cfg_rd_data;
    logic           cfg_rd_data_valid;
    logic           ram_wr_en;
    logic [3:0]     ram_wr_addr;
    logic [DW-1:0]  ram_wr_data;
    logic           ram_rd_en;
    logic [3:0]     ram_rd_addr;
    logic [DW-1:0]  ram_rd_data;
    logic [2:0]     dbg_state;

    ram_entry_loader dut (
        .axi_clk           (clk),
        .axi_rst           (rst),
        .cfg_wr_valid      (cfg_wr_valid),
        .cfg_wr_ready      (cfg_wr_ready),
        .cfg_wr_idx        (cfg_wr_idx),
        .cfg_wr_data       (cfg_wr_data),
        .cfg_rd_valid      (cfg_rd_valid),
        .cfg_rd_ready      (cfg_rd_ready),
        .cfg_rd_idx        (cfg_rd_idx),
        .cfg_rd_data       (cfg_rd_data),
        .cfg_rd_data_valid (cfg_rd_data_valid),
        .ram_wr_en         (ram_wr_en),
        .ram_wr_addr       (ram_wr_addr),
        .ram_wr_data       (ram_wr_data),
        .ram_rd_en         (ram_rd_en),
        .ram_rd_addr       (ram_rd_addr),
        .ram_rd_data       (ram_rd_data),
        .dbg_state         (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- table RAM (registered read) ----------------
    logic [DW-1:0] mem [16];
    logic [DW-1:0] ram_q;
    assign ram_rd_data = ram_q;

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_q <= mem[ram_rd_addr];
    end

    // ---------------- counters / check helper ----------------
    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Transaction view: staging words, a RAM shadow, last command, and the
    // number of busy cycles still owed by the command in flight.
    logic [31:0]   m_words [9];
    logic [DW-1:0] m_ram [16];
    logic [3:0]    m_addr = '0;
    logic          m_op = 1'b0;
    logic          m_done = 1'b0;
    int            m_left = 0;
    int            m_len = 0;
    logic          m_rd_valid = 1'b0;
    logic [31:0]   m_rd_data = '0;

    function automatic logic [DW-1:0] m_flat();
        logic [DW-1:0] v;
        v = '0;
        for (int k = 0; k < 9; k++)
            for (int b = 0; b < 32; b++)
                if (k * 32 + b < DW) v[k * 32 + b] = m_words[k][b];
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] idx);
        if (idx < 4'd9) return m_words[idx];
        if (idx == 4'd10) return {24'h0, m_addr, 1'b0, m_op, m_done, (m_left > 0)};
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) m_words[k] = '0;
            m_addr = '0; m_op = 1'b0; m_done = 1'b0;
            m_left = 0; m_len = 0;
            m_rd_valid = 1'b0; m_rd_data = '0;
        end else begin
            // Read response reflects state before this edge.
            m_rd_valid = cfg_rd_valid;
            if (cfg_rd_valid) m_rd_data = m_read(cfg_rd_idx);
            if (m_left > 0) begin
                if (m_left == m_len && !m_op) m_ram[m_addr] = m_flat();
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    if (m_op)
                        for (int k = 0; k < 9; k++)
                            for (int b = 0; b < 32; b++)
                                m_words[k][b] = (k * 32 + b < DW) ? m_ram[m_addr][k * 32 + b] : 1'b0;
                end
            end else if (cfg_wr_valid) begin
                if (cfg_wr_idx < 4'd8) m_words[cfg_wr_idx] = cfg_wr_data;
                else if (cfg_wr_idx == 4'd8) m_words[8] = cfg_wr_data & 32'h7FF;
                else if (cfg_wr_idx == 4'd9 && cfg_wr_data[0]) begin
                    m_op   = cfg_wr_data[1];
                    m_addr = cfg_wr_data[7:4];
                    m_done = 1'b0;
                    m_len  = m_op ? 3 : 1;
                    m_left = m_len;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    logic [DW-1:0] last_wr_data = '0;
    logic [3:0]    last_wr_addr = '0;
    logic [3:0]    last_rd_addr = '0;

    always @(negedge clk) begin
        logic exp_wr, exp_rd;
        if (chk_en) begin
            exp_wr = !rst && m_left > 0 && m_left == m_len && !m_op;
            exp_rd = !rst && m_left > 0 && m_left == m_len && m_op;
            chk("cfg_wr_ready", DW'(cfg_wr_ready), DW'(!rst && m_left == 0));
            chk("cfg_rd_ready", DW'(cfg_rd_ready), DW'(!rst));
            chk("ram_wr_en", DW'(ram_wr_en), DW'(exp_wr));
            chk("ram_rd_en", DW'(ram_rd_en), DW'(exp_rd));
            if (exp_wr) begin
                chk("ram_wr_addr", DW'(ram_wr_addr), DW'(m_addr));
                chk("ram_wr_data", ram_wr_data, m_flat());
            end
            if (exp_rd) chk("ram_rd_addr", DW'(ram_rd_addr), DW'(m_addr));
            chk("cfg_rd_data_valid", DW'(cfg_rd_data_valid), DW'(m_rd_valid));
            if (m_rd_valid) chk("cfg_rd_data", DW'(cfg_rd_data), DW'(m_rd_data));
        end
        if (ram_wr_en) begin
            wr_cnt++; last_wr_data = ram_wr_data; last_wr_addr = ram_wr_addr;
        end
        if (ram_rd_en) begin
            rd_cnt++; last_rd_addr = ram_rd_addr;
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic drive(input logic wv, input logic [3:0] widx, input logic [31:0] wdata,
                         input logic rv, input logic [3:0] ridx);
        int guard;
        logic acc;
        cfg_wr_valid = wv; cfg_wr_idx = widx; cfg_wr_data = wdata;
        cfg_rd_valid = rv; cfg_rd_idx = ridx;
        guard = 0;
        forever begin
            @(negedge clk);
            acc = !wv || cfg_wr_ready;
            @(posedge clk); #1;
            cfg_rd_valid = 1'b0;
            if (acc) break;
            guard++;
            if (guard > 64) begin
                n_vec++; n_err++;
                $display("FAIL wr_accept_timeout: got ready=0 for %0d cycles expected acceptance", guard);
                break;
            end
        end
        cfg_wr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rd(input logic [3:0] idx, output logic [31:0] d);
        drive(1'b0, 4'd0, 32'h0, 1'b1, idx);
        d = cfg_rd_data;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [DW-1:0] v;
        int w0, r0, sel;
        for (int i = 0; i < 16; i++) begin
            for (int b = 0; b < DW; b++) v[b] = 1'($urandom_range(0, 1));
            mem[i] = v; m_ram[i] = v;
        end
        for (int k = 0; k < 9; k++) m_words[k] = '0;
        ram_q = '0;
        rst = 1'b1; cfg_wr_valid = 1'b0; cfg_wr_idx = '0; cfg_wr_data = '0;
        cfg_rd_valid = 1'b0; cfg_rd_idx = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        idle(2);
        chk("rst_ram_wr_addr", DW'(ram_wr_addr), '0);
        chk("rst_ram_rd_addr", DW'(ram_rd_addr), '0);
        chk("rst_cfg_rd_data", DW'(cfg_rd_data), '0);
        chk("rst_wr_ready", DW'(cfg_wr_ready), '0);
        rst = 1'b0;
        #1;
        chk("wr_ready_after_rst", DW'(cfg_wr_ready), DW'(1));
        rd(4'd10, d); chk("status_after_rst", DW'(d), DW'(32'h0));
        rd(4'd3, d);  chk("word3_after_rst", DW'(d), DW'(32'h0));

        // Commit a known entry to address 3.
        for (int k = 0; k < 9; k++) drive(1'b1, 4'(k), 32'h11111111 * (k + 1), 1'b0, 4'd0);
        w0 = wr_cnt;
        drive(1'b1, 4'd9, 32'h31, 1'b0, 4'd0);
        idle(1);
        chk("wr_strobe_count", DW'(wr_cnt - w0), DW'(1));
        chk("wr_addr_lit", DW'(last_wr_addr), DW'(3));
        chk("wr_data_top_lit", DW'(last_wr_data[266:256]), DW'(11'h199));
        chk("wr_data_low_lit", DW'(last_wr_data[31:0]), DW'(32'h11111111));
        rd(4'd10, d); chk("status_after_wr", DW'(d), DW'(32'h32));

        // Clear staging, read entry 3 back.
        for (int k = 0; k < 9; k++) drive(1'b1, 4'(k), 32'h0, 1'b0, 4'd0);
        r0 = rd_cnt;
        drive(1'b1, 4'd9, 32'h33, 1'b0, 4'd0);
        idle(3);
        chk("rd_strobe_count", DW'(rd_cnt - r0), DW'(1));
        chk("rd_addr_lit", DW'(last_rd_addr), DW'(3));
        for (int k = 0; k < 8; k++) begin
            rd(4'(k), d); chk("readback_word", DW'(d), DW'(32'h11111111 * (k + 1)));
        end
        rd(4'd8, d);  chk("readback_word8", DW'(d), DW'(32'h199));
        rd(4'd10, d); chk("status_after_rd", DW'(d), DW'(32'h36));

        // Writes stall while busy, then land.
        drive(1'b1, 4'd9, 32'h51, 1'b0, 4'd0);
        drive(1'b1, 4'd0, 32'hDEADBEEF, 1'b0, 4'd0);
        chk("stalled_wr_entry5", mem[5], {11'h199, 32'h88888888, 32'h77777777, 32'h66666666,
            32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        drive(1'b1, 4'd9, 32'h33, 1'b0, 4'd0);
        drive(1'b1, 4'd1, 32'hCAFEF00D, 1'b0, 4'd0);
        rd(4'd0, d); chk("stalled_word0", DW'(d), DW'(32'h11111111));
        rd(4'd1, d); chk("stalled_word1", DW'(d), DW'(32'hCAFEF00D));

        // go = 0, ignored indices.
        w0 = wr_cnt; r0 = rd_cnt;
        drive(1'b1, 4'd9, 32'h52, 1'b0, 4'd0);
        drive(1'b1, 4'd12, 32'hFFFFFFFF, 1'b0, 4'd0);
        idle(3);
        chk("go0_no_strobe", DW'((wr_cnt - w0) + (rd_cnt - r0)), DW'(0));
        rd(4'd12, d); chk("idx12_reads0", DW'(d), DW'(0));
        rd(4'd9, d);  chk("cmd_reads0", DW'(d), DW'(0));

        // Reset while waiting on RAM data.
        drive(1'b1, 4'd9, 32'h73, 1'b0, 4'd0);
        idle(1);
        rst = 1'b1;
        w0 = wr_cnt; r0 = rd_cnt;
        idle(2);
        rst = 1'b0;
        idle(4);
        chk("rst_mid_no_strobe", DW'((wr_cnt - w0) + (rd_cnt - r0)), DW'(0));
        rd(4'd10, d); chk("rst_mid_status", DW'(d), DW'(0));
        rd(4'd0, d);  chk("rst_mid_word0", DW'(d), DW'(0));

        // Randomized traffic.
        for (int it = 0; it < 400; it++) begin
            sel = $urandom_range(0, 99);
            if (sel < 4) begin
                rst = 1'b1; idle($urandom_range(1, 2)); rst = 1'b0;
            end else if (sel < 25) begin
                d = {24'h0, 4'($urandom_range(0, 15)), 2'b00, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 7) != 0)};
                drive(1'b1, 4'd9, d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            end else if (sel < 60) begin
                drive(1'b1, 4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)));
            end else if (sel < 85) begin
                rd(4'($urandom_range(0, 15)), d);
            end else begin
                idle($urandom_range(1, 3));
            end
        end
        idle(6);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
